// File: rtl/sr_pulse_driver.sv
`timescale 1ns/1ps
// sr_pulse_driver
// Driver end of an RS set/reset interface. Two raw, bouncy board switches
// are synchronised, debounced and rising-edge detected; the resulting set and
// reset requests are arbitrated into clean, mutually exclusive, fixed-width
// S/R pulses for a downstream cross-coupled NOR latch. A shadow of the
// expected latch Q and a forbidden-input indicator are kept for LEDs.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active high
//   sw1_S      raw set switch (asynchronous, bouncy)
//   sw2_R      raw reset switch (asynchronous, bouncy)
//   s_out      set pulse to latch S, PULSE_LEN cycles wide
//   r_out      reset pulse to latch R, PULSE_LEN cycles wide
//   led_q      shadow of expected latch Q
//   led_err    forbidden S=R=1 request indicator
//   pulse_cnt  count of issued pulses (mod 256)
//
// Optional feature macro: SR_PULSE_CNT_EN
//   defined   -> pulse_cnt counts pulse starts and wraps 255 -> 0
//   undefined -> pulse_cnt is tied to 0
//
// FSM states:
//   state   | meaning
//   IDLE    | waiting for a set/reset request or a pending one
//   PULSE_S | s_out high, width counter running
//   PULSE_R | r_out high, width counter running
//   GAP     | one cycle with both outputs low before the next decision

module sr_pulse_driver #(
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int CNT_W        = 20,
    parameter int PULSE_LEN    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw1_S,
    input  logic       sw2_R,
    output logic       s_out,
    output logic       r_out,
    output logic       led_q,
    output logic       led_err,
    output logic [7:0] pulse_cnt
);

    localparam int WC_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [WC_W-1:0]  W_LAST  = WC_W'(PULSE_LEN - 1);

    typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

    // Channel index 0 is the set switch, 1 is the reset switch.
    logic [1:0]       sw_raw;
    logic [1:0]       sync_m;
    logic [1:0]       sync_x;
    logic [1:0]       stb;
    logic [1:0]       stb_d;
    logic [1:0]       req;
    logic [CNT_W-1:0] cnt [2];

    state_t          state, state_nxt;
    logic [WC_W-1:0] wcnt, wcnt_nxt;
    logic            pend_s, pend_s_nxt;
    logic            pend_r, pend_r_nxt;
    logic            led_q_nxt;
    logic            led_err_nxt;
    logic            want_s, want_r;

    assign sw_raw = {sw2_R, sw1_S};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_m <= '0;
            sync_x <= '0;
        end else begin
            sync_m <= sw_raw;
            sync_x <= sync_m;
        end
    end

    // A level is accepted only after DEBOUNCE_CNT consecutive mismatch
    // cycles; any bounce back to the stable level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb    <= '0;
            stb_d  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            stb_d <= stb;
            for (int i = 0; i < 2; i++) begin
                if (sync_x[i] == stb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    stb[i] <= ~stb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign req    = stb & ~stb_d;
    assign want_s = req[0] | pend_s;
    assign want_r = req[1] | pend_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wcnt    <= '0;
            pend_s  <= 1'b0;
            pend_r  <= 1'b0;
            led_q   <= 1'b0;
            led_err <= 1'b0;
            s_out   <= 1'b0;
            r_out   <= 1'b0;
        end else begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            pend_s  <= pend_s_nxt;
            pend_r  <= pend_r_nxt;
            led_q   <= led_q_nxt;
            led_err <= led_err_nxt;
            // Outputs are registered from the next state so they line up
            // exactly with PULSE_S / PULSE_R occupancy.
            s_out   <= (state_nxt == PULSE_S);
            r_out   <= (state_nxt == PULSE_R);
        end
    end

    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = wcnt;
        pend_s_nxt  = pend_s;
        pend_r_nxt  = pend_r;
        led_q_nxt   = led_q;
        led_err_nxt = led_err;

        if (led_err && !stb[0] && !stb[1]) begin
            led_err_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                // While led_err is up, requests are simply dropped.
                if (!led_err) begin
                    if (want_s && want_r) begin
                        led_err_nxt = 1'b1;
                        pend_s_nxt  = 1'b0;
                        pend_r_nxt  = 1'b0;
                    end else if (want_s) begin
                        state_nxt  = PULSE_S;
                        pend_s_nxt = 1'b0;
                        wcnt_nxt   = W_LAST;
                    end else if (want_r) begin
                        state_nxt  = PULSE_R;
                        pend_r_nxt = 1'b0;
                        wcnt_nxt   = W_LAST;
                    end
                end
            end
            PULSE_S, PULSE_R: begin
                pend_s_nxt = pend_s | req[0];
                pend_r_nxt = pend_r | req[1];
                if (wcnt == '0) begin
                    state_nxt = GAP;
                    led_q_nxt = (state == PULSE_S);
                end else begin
                    wcnt_nxt = wcnt - WC_W'(1);
                end
            end
            GAP: begin
                pend_s_nxt = pend_s | req[0];
                pend_r_nxt = pend_r | req[1];
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef SR_PULSE_CNT_EN
    logic [7:0] pcnt;

    // The only way out of IDLE is into a pulse state, so this marks the
    // first cycle of every pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (state == IDLE && state_nxt != IDLE) begin
            pcnt <= pcnt + 8'd1;
        end
    end

    assign pulse_cnt = pcnt;
`else
    assign pulse_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
`timescale 1ns/1ps
// tb_sr_pulse_driver
// Directed and randomised switch stimulus for sr_pulse_driver with
// DEBOUNCE_CNT=4, PULSE_LEN=4. A cycle-level reference model phrased in
// terms of run lengths and remaining-pulse counters predicts every output
// each cycle; directed scenarios add latency/width/gap/wrap checks.

module tb_sr_pulse_driver;

    localparam int DEB = 4;
    localparam int PL  = 4;
`ifdef SR_PULSE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw1_S = 1'b0;
    logic       sw2_R = 1'b0;
    logic       s_out, r_out, led_q, led_err;
    logic [7:0] pulse_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    sr_pulse_driver #(
        .DEBOUNCE_CNT (DEB),
        .CNT_W        (20),
        .PULSE_LEN    (PL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw1_S     (sw1_S),
        .sw2_R     (sw2_R),
        .s_out     (s_out),
        .r_out     (r_out),
        .led_q     (led_q),
        .led_err   (led_err),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_s1 [2], m_sy [2], m_stb [2], m_stbd [2], m_run [2], m_pend [2];
    int m_req [2], m_sw [2];
    int m_busy_s, m_busy_r, m_gap, m_cnt;
    bit m_q, m_err;
    bit ws, wr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_sy[i] = 0; m_stb[i] = 0; m_stbd[i] = 0;
                m_run[i] = 0; m_pend[i] = 0;
            end
            m_busy_s = 0; m_busy_r = 0; m_gap = 0; m_cnt = 0;
            m_q = 1'b0; m_err = 1'b0;
        end else begin
            m_sw[0] = int'(sw1_S);
            m_sw[1] = int'(sw2_R);
            for (int i = 0; i < 2; i++) m_req[i] = (m_stb[i] == 1 && m_stbd[i] == 0) ? 1 : 0;

            if (m_busy_s == 0 && m_busy_r == 0 && m_gap == 0) begin
                if (m_err) begin
                    if (m_stb[0] == 0 && m_stb[1] == 0) m_err = 1'b0;
                end else begin
                    ws = (m_req[0] != 0) || (m_pend[0] != 0);
                    wr = (m_req[1] != 0) || (m_pend[1] != 0);
                    if (ws && wr) begin
                        m_err = 1'b1; m_pend[0] = 0; m_pend[1] = 0;
                    end else if (ws) begin
                        m_busy_s = PL; m_pend[0] = 0; m_cnt = (m_cnt + 1) % 256;
                    end else if (wr) begin
                        m_busy_r = PL; m_pend[1] = 0; m_cnt = (m_cnt + 1) % 256;
                    end
                end
            end else begin
                for (int i = 0; i < 2; i++) if (m_req[i] != 0) m_pend[i] = 1;
                if (m_gap > 0) begin
                    m_gap = 0;
                end else if (m_busy_s > 0) begin
                    m_busy_s--;
                    if (m_busy_s == 0) begin m_q = 1'b1; m_gap = 1; end
                end else begin
                    m_busy_r--;
                    if (m_busy_r == 0) begin m_q = 1'b0; m_gap = 1; end
                end
            end

            // DEB consecutive disagreeing samples flip the accepted level.
            for (int i = 0; i < 2; i++) begin
                m_stbd[i] = m_stb[i];
                if (m_sy[i] != m_stb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_stb[i] = 1 - m_stb[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_sy[i] = m_s1[i];
                m_s1[i] = m_sw[i];
            end
        end
    end

    // ---------------- per-cycle compare and edge monitor ----------------
    int cyc_n = 0;
    int s_rise, s_fall, r_rise, r_fall;
    int n_sp = 0, n_rp = 0;
    logic s_prev = 1'b0, r_prev = 1'b0;

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (!rst) begin
            chk("outs", {28'd0, s_out, r_out, led_q, led_err},
                {28'd0, m_busy_s > 0, m_busy_r > 0, m_q, m_err});
            chk("pcnt", {24'd0, pulse_cnt}, CNT_ON ? m_cnt : 0);
            chk("excl", {31'd0, s_out & r_out}, 0);
        end
        if (s_out && !s_prev) begin s_rise = cyc_n; n_sp++; end
        if (!s_out && s_prev) s_fall = cyc_n;
        if (r_out && !r_prev) begin r_rise = cyc_n; n_rp++; end
        if (!r_out && r_prev) r_fall = cyc_n;
        s_prev = s_out;
        r_prev = r_out;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sw(input int ch, input logic v);
        if (ch == 0) sw1_S = v;
        else         sw2_R = v;
    endtask

    task automatic press(input int ch, input logic lvl, input int nb);
        set_sw(ch, lvl);
        for (int k = 0; k < nb; k++) begin
            cyc($urandom_range(1, 3));
            set_sw(ch, !lvl);
            cyc($urandom_range(1, 3));
            set_sw(ch, lvl);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sw1_S = 1'b0;
        sw2_R = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "time limit");
    end

    int c0, np0, nr0, mode;

    initial begin
        // reset state
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("rst_s", {31'd0, s_out}, 0);
        chk("rst_r", {31'd0, r_out}, 0);
        chk("rst_q", {31'd0, led_q}, 0);
        chk("rst_err", {31'd0, led_err}, 0);
        chk("rst_pcnt", {24'd0, pulse_cnt}, 0);

        // clean set: pulse starts 7 cycles after the edge, 4 wide
        c0 = cyc_n; np0 = n_sp; nr0 = n_rp;
        sw1_S = 1'b1;
        cyc(20);
        chk("set_cnt", n_sp - np0, 1);
        chk("set_lat", s_rise - c0, 2 + DEB + 1);
        chk("set_wid", s_fall - s_rise, PL);
        chk("set_q", {31'd0, led_q}, 1);
        chk("set_nor", n_rp - nr0, 0);
        chk("set_pcnt", {24'd0, pulse_cnt}, CNT_ON ? 1 : 0);
        sw1_S = 1'b0;
        cyc(12);

        // bounce 1,0,1,0 at 2-cycle spacing then hold: one pulse from last edge
        np0 = n_sp;
        sw1_S = 1'b1; cyc(2);
        sw1_S = 1'b0; cyc(2);
        sw1_S = 1'b1; cyc(2);
        sw1_S = 1'b0; cyc(2);
        c0 = cyc_n;
        sw1_S = 1'b1;
        cyc(20);
        chk("bnc_cnt", n_sp - np0, 1);
        chk("bnc_lat", s_rise - c0, 2 + DEB + 1);
        sw1_S = 1'b0;
        cyc(12);

        // forbidden: both rise together
        np0 = n_sp; nr0 = n_rp;
        sw1_S = 1'b1; sw2_R = 1'b1;
        cyc(20);
        chk("fbd_s", n_sp - np0, 0);
        chk("fbd_r", n_rp - nr0, 0);
        chk("fbd_err", {31'd0, led_err}, 1);
        sw1_S = 1'b0; sw2_R = 1'b0;
        cyc(12);
        chk("fbd_clr", {31'd0, led_err}, 0);

        // queued: reset request lands while PULSE_S runs
        np0 = n_sp; nr0 = n_rp;
        sw1_S = 1'b1;
        cyc(2);
        sw2_R = 1'b1;
        cyc(25);
        chk("que_s", n_sp - np0, 1);
        chk("que_r", n_rp - nr0, 1);
        // low for the GAP cycle plus the IDLE cycle that picks up the pending reset
        chk("que_gap", r_rise - s_fall, 2);
        chk("que_wid", r_fall - r_rise, PL);
        chk("que_q", {31'd0, led_q}, 0);
        sw1_S = 1'b0; sw2_R = 1'b0;
        cyc(12);

        // reset mid-pulse drops everything immediately
        c0 = cyc_n;
        sw1_S = 1'b1;
        cyc(8);
        chk("mid_pulse", {31'd0, s_out}, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_s", {31'd0, s_out}, 0);
        chk("arst_r", {31'd0, r_out}, 0);
        chk("arst_q", {31'd0, led_q}, 0);
        chk("arst_err", {31'd0, led_err}, 0);
        chk("arst_pcnt", {24'd0, pulse_cnt}, 0);
        sw1_S = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(5);
        c0 = cyc_n; nr0 = n_rp;
        sw2_R = 1'b1;
        cyc(20);
        chk("post_cnt", n_rp - nr0, 1);
        chk("post_lat", r_rise - c0, 2 + DEB + 1);
        sw2_R = 1'b0;
        cyc(12);

        // randomised traffic checked cycle-by-cycle against the model
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 3));
            if (mode < 2) begin
                press(mode, 1'b1, int'($urandom_range(0, 3)));
                cyc($urandom_range(8, 20));
                press(mode, 1'b0, int'($urandom_range(0, 3)));
                cyc($urandom_range(10, 25));
            end else if (mode == 2) begin
                sw1_S = 1'b1; sw2_R = 1'b1;
                cyc($urandom_range(8, 20));
                sw1_S = 1'b0; sw2_R = 1'b0;
                cyc($urandom_range(10, 25));
            end else begin
                sw1_S = 1'b1;
                cyc($urandom_range(0, 8));
                sw2_R = 1'b1;
                cyc(20);
                sw1_S = 1'b0; sw2_R = 1'b0;
                cyc(20);
            end
        end

        // wrap: 256 alternating pulses from a clean reset
        do_reset();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) chk("wrap_255", {24'd0, pulse_cnt}, CNT_ON ? 255 : 0);
            set_sw(i % 2, 1'b1);
            cyc(13);
            set_sw(i % 2, 1'b0);
            cyc(8);
        end
        cyc(5);
        chk("wrap_0", {24'd0, pulse_cnt}, 0);
        chk("wrap_q", {31'd0, led_q}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_pulse_driver.md
Name: sr_pulse_driver

Overview:
- Driver end of an RS set/reset interface. It turns two raw board switches into clean, mutually exclusive, fixed-width S and R pulses for a cross-coupled NOR latch.
- It synchronises and debounces each switch, then edge-detects the debounced level.
- It arbitrates the set and reset requests, rejects the forbidden S=R=1 case, and keeps a shadow copy of the latch state that it expects.
- It sits between the switch bank and any downstream RS-latch stage.

Parameters:
- DEBOUNCE_CNT, 1000000, number of consecutive stable cycles before a switch level is accepted (20 ms at 50 MHz); must be >= 2.
- CNT_W, 20, width of each debounce counter; must hold DEBOUNCE_CNT-1.
- PULSE_LEN, 4, width of each S/R output pulse in clock cycles; must be >= 1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous reset, active high.
- sw1_S, input, 1, raw set switch; asynchronous and bouncy.
- sw2_R, input, 1, raw reset switch; asynchronous and bouncy.
- s_out, output, 1, set pulse to the latch S input.
- r_out, output, 1, reset pulse to the latch R input.
- led_q, output, 1, shadow of the expected latch Q.
- led_err, output, 1, forbidden-input indicator.
- pulse_cnt, output, 8, count of issued pulses (see Optional Feature).

Behaviour:
- Reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - Every flop clears to 0, including both synchronisers, debounce counters, stable levels, pending flags, FSM (state IDLE), s_out, r_out, led_q, led_err and pulse_cnt.
  - Reset asserted mid-pulse drops s_out and r_out on the same cycle (asynchronously).
- Synchronise:
  - Each switch passes through a 2-flop synchroniser, giving sync_x.
- Debounce, per channel:
  - State is a stable level stb_x and a counter cnt_x.
  - If sync_x == stb_x, cnt_x clears to 0.
  - Otherwise cnt_x increments. When cnt_x == DEBOUNCE_CNT-1 on a mismatch cycle, stb_x toggles and cnt_x clears.
  - Any bounce back to stb_x clears the count.
- Edge detect:
  - req_x is asserted for 1 cycle on each 0->1 transition of stb_x.
  - Falling edges produce no request.
- Latency:
  - A clean switch rising edge produces an output pulse exactly 2 + DEBOUNCE_CNT + 1 cycles later, when the FSM is IDLE.
- Pending flags:
  - A req_x arriving in a non-IDLE state sets pend_x.
  - Pending depth is one per channel; further requests while pending are dropped.
- FSM states: IDLE, PULSE_S, PULSE_R, GAP.
- IDLE:
  - If req_S and req_R are both high in the same cycle, set led_err, issue no pulse and clear both pending flags.
  - Else if (req_S or pend_S) and (req_R or pend_R), also treat it as forbidden (led_err=1, drop both).
  - Else if req_S or pend_S: go to PULSE_S and clear pend_S.
  - Else if req_R or pend_R: go to PULSE_R and clear pend_R.
- PULSE_S / PULSE_R:
  - The output (s_out or r_out) is registered and high for exactly PULSE_LEN cycles. A width counter drives the duration.
  - The other output stays 0; s_out and r_out are never high together.
  - On the last cycle, update led_q (PULSE_S sets it to 1, PULSE_R sets it to 0) and go to GAP.
- GAP:
  - Exactly 1 cycle with both outputs low, then return to IDLE.
- led_err:
  - Stays set until stb_S and stb_R are both 0, then clears on the next cycle.
  - No pulses are issued while led_err is 1; requests arriving in that period are discarded.
- Repeated requests:
  - Repeated set while led_q=1 still issues a pulse (idempotent on the latch).

Optional Feature:
- Macro: SR_PULSE_CNT_EN.
- Defined: pulse_cnt is an 8-bit counter.
  - Increments by 1 on the first cycle of every PULSE_S or PULSE_R.
  - Wraps from 255 to 0.
  - Cleared by rst.
- Undefined: pulse_cnt is tied to 8'd0 and no counter logic is synthesised.

Test Plan:
- Bench uses DEBOUNCE_CNT=4 and PULSE_LEN=4.
- Reset: assert rst mid-operation -> s_out=0, r_out=0, led_q=0, led_err=0 and pulse_cnt=0 immediately; FSM in IDLE after release.
- Clean set: sw1_S 0->1 and held -> s_out high for exactly 4 cycles starting 7 cycles after the edge; led_q=1 afterwards; r_out stays 0; pulse_cnt=1 (macro defined).
- Bounce: sw1_S toggles 1,0,1,0 at 2-cycle intervals, then holds 1 -> exactly one s_out pulse, timed from the final stable edge.
- Forbidden: sw1_S and sw2_R rise on the same cycle and are held -> no pulses, led_err=1. Release both -> led_err clears after debounce; outputs never both 1.
- Queued: sw2_R rises while a PULSE_S is in progress -> PULSE_S completes, 1 GAP cycle, then r_out high for 4 cycles; final led_q=0.
- Wrap: 256 alternating set/reset pulses -> pulse_cnt returns to 0 (macro defined); pulse_cnt stays 0 throughout (macro undefined).
